// File: rtl/mining_job_controller.sv
// Job sequencer for sha_block: accept job, load, solve, report one result.
// Optional solve-phase timeout is built when JOB_TIMEOUT_EN is defined.
module mining_job_controller #(
  parameter int unsigned LOAD_CYCLES    = 2,
  parameter logic [31:0] NONCE_LIMIT    = 32'h7FFF_FFFF,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [511:0] job_head,
  input  logic         abort,
  output logic [255:0] midState,
  output logic [511:0] headData,
  output logic         loadState,
  output logic         solveEn,
  input  logic         flag,
  input  logic [31:0]  goldenNonce,
  input  logic [31:0]  sha_counter,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic         result_timeout,
  output logic [31:0]  result_nonce,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SOLVE,
    REPORT
  } state_e;

  localparam logic [31:0] LOAD_LAST = 32'(LOAD_CYCLES - 1);

  state_e         state_q, state_d;
  logic [31:0]    load_cnt_q, load_cnt_d;
  logic [255:0]   mid_q, mid_d;
  logic [511:0]   head_q, head_d;
  logic           found_q, found_d;
  logic           tout_q, tout_d;
  logic [31:0]    nonce_q, nonce_d;
  logic           job_ready_q, load_q, solve_q;
  logic           valid_q, busy_q;
  logic           timeout_hit;

`ifdef JOB_TIMEOUT_EN
  logic [31:0] sol_cnt_q, sol_cnt_d;

  // Held at zero outside SOLVE, so it restarts on every entry.
  always_comb begin
    sol_cnt_d = '0;
    if (state_q == SOLVE) sol_cnt_d = sol_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sol_cnt_q <= '0;
    else        sol_cnt_q <= sol_cnt_d;
  end

  assign timeout_hit = (sol_cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_tout;
  assign unused_tout = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    mid_d      = mid_q;
    head_d     = head_q;
    found_d    = found_q;
    tout_d     = tout_q;
    nonce_d    = nonce_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (job_valid) begin
            mid_d      = job_midstate;
            head_d     = job_head;
            load_cnt_d = '0;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          if (load_cnt_q == LOAD_LAST) state_d = SOLVE;
          else load_cnt_d = load_cnt_q + 32'd1;
        end
        SOLVE: begin
          if (flag) begin
            found_d = 1'b1;
            tout_d  = 1'b0;
            nonce_d = goldenNonce;
            state_d = REPORT;
          end else if (sha_counter >= NONCE_LIMIT) begin
            found_d = 1'b0;
            tout_d  = 1'b0;
            nonce_d = '0;
            state_d = REPORT;
          end else if (timeout_hit) begin
            found_d = 1'b0;
            tout_d  = 1'b1;
            nonce_d = '0;
            state_d = REPORT;
          end
        end
        REPORT: begin
          if (result_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      mid_q       <= '0;
      head_q      <= '0;
      found_q     <= 1'b0;
      tout_q      <= 1'b0;
      nonce_q     <= '0;
      job_ready_q <= 1'b1;
      load_q      <= 1'b0;
      solve_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      mid_q       <= mid_d;
      head_q      <= head_d;
      found_q     <= found_d;
      tout_q      <= tout_d;
      nonce_q     <= nonce_d;
      job_ready_q <= (state_d == IDLE);
      load_q      <= (state_d == LOAD);
      solve_q     <= (state_d == SOLVE);
      valid_q     <= (state_d == REPORT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign job_ready      = job_ready_q;
  assign midState       = mid_q;
  assign headData       = head_q;
  assign loadState      = load_q;
  assign solveEn        = solve_q;
  assign result_valid   = valid_q;
  assign result_found   = found_q;
  assign result_timeout = tout_q;
  assign result_nonce   = nonce_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mining_job_controller.sv
// Directed self-checking bench for mining_job_controller.
// Runs with NONCE_LIMIT=16, TIMEOUT_CYCLES=50, LOAD_CYCLES=2.
module tb_mining_job_controller;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [511:0] job_head;
  logic         abort;
  logic [255:0] midState;
  logic [511:0] headData;
  logic         loadState;
  logic         solveEn;
  logic         flag;
  logic [31:0]  goldenNonce;
  logic [31:0]  sha_counter;
  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic         result_timeout;
  logic [31:0]  result_nonce;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] MID_A = {8{32'h1111_2222}};
  localparam logic [511:0] HEAD_A = {16{32'h3333_4444}};
  localparam logic [255:0] MID_B = {8{32'hCAFE_F00D}};
  localparam logic [511:0] HEAD_B = {16{32'h0BAD_C0DE}};

  mining_job_controller #(
    .LOAD_CYCLES(2),
    .NONCE_LIMIT(32'd16),
    .TIMEOUT_CYCLES(32'd50)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_midstate(job_midstate),
    .job_head(job_head),
    .abort(abort),
    .midState(midState),
    .headData(headData),
    .loadState(loadState),
    .solveEn(solveEn),
    .flag(flag),
    .goldenNonce(goldenNonce),
    .sha_counter(sha_counter),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_found(result_found),
    .result_timeout(result_timeout),
    .result_nonce(result_nonce),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a job and advance to the first SOLVE cycle.
  task automatic start_job(input logic [255:0] m, input logic [511:0] h);
    job_midstate = m;
    job_head     = h;
    job_valid    = 1'b1;
    step();
    job_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    job_valid = 0; job_midstate = '0; job_head = '0;
    abort = 0; flag = 0; goldenNonce = '0; sha_counter = '0;
    result_ready = 0;
    #12;
    checks++;
    if ({job_ready, busy, loadState, solveEn} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000",
               {job_ready, busy, loadState, solveEn});
    end
    checks++;
    if ({result_valid, result_found, result_timeout} !== 3'b000 ||
        result_nonce !== 32'd0) begin
      errors++;
      $display("FAIL reset_result got v%b f%b t%b n%h want 0 0 0 0",
               result_valid, result_found, result_timeout, result_nonce);
    end
    checks++;
    if (midState !== '0 || headData !== '0) begin
      errors++;
      $display("FAIL reset_data got mid %h want 0", midState[31:0]);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_found();
    int lc;
    job_midstate = MID_A;
    job_head     = HEAD_A;
    job_valid    = 1'b1;
    step();
    job_valid = 1'b0;
    checks++;
    if (job_ready !== 1'b0 || midState !== MID_A || headData !== HEAD_A) begin
      errors++;
      $display("FAIL accept got rdy %b mid %h want 0 %h",
               job_ready, midState[31:0], MID_A[31:0]);
    end
    lc = 0;
    while (loadState === 1'b1 && lc < 10) begin
      lc++;
      step();
    end
    checks++;
    if (lc !== 2 || solveEn !== 1'b1) begin
      errors++;
      $display("FAIL load_len got %0d cycles solve %b want 2 1", lc, solveEn);
    end
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (solveEn !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL solve_hold got s%b v%b want 1 0", solveEn, result_valid);
    end
    flag = 1'b1;
    goldenNonce = 32'hDEAD_BEEF;
    step();
    flag = 1'b0;
    goldenNonce = 32'h0;
    checks++;
    if (result_valid !== 1'b1 || result_found !== 1'b1 ||
        result_nonce !== 32'hDEAD_BEEF || solveEn !== 1'b0 ||
        result_timeout !== 1'b0) begin
      errors++;
      $display("FAIL found got v%b f%b n%h s%b t%b want 1 1 deadbeef 0 0",
               result_valid, result_found, result_nonce, solveEn,
               result_timeout);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake got v%b r%b b%b want 0 1 0",
               result_valid, job_ready, busy);
    end
  endtask

  task automatic test_exhaust();
    job_midstate = MID_B;
    job_head     = HEAD_B;
    job_valid    = 1'b1;
    step();
    job_valid = 1'b0;
    flag = 1'b1;
    goldenNonce = 32'h5555_5555;
    step();
    flag = 1'b0;
    checks++;
    if (loadState !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flag_in_load got l%b v%b want 1 0",
               loadState, result_valid);
    end
    step();
    sha_counter = 32'd15;
    step();
    checks++;
    if (solveEn !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL below_limit got s%b v%b want 1 0", solveEn, result_valid);
    end
    sha_counter = 32'h8000_0000;
    step();
    sha_counter = 32'd0;
    checks++;
    if (result_valid !== 1'b1 || result_found !== 1'b0 ||
        result_nonce !== 32'd0 || solveEn !== 1'b0) begin
      errors++;
      $display("FAIL exhaust got v%b f%b n%h s%b want 1 0 0 0",
               result_valid, result_found, result_nonce, solveEn);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    start_job(MID_A, HEAD_A);
    sha_counter = 32'd16;
    flag = 1'b1;
    goldenNonce = 32'h1234_5678;
    step();
    flag = 1'b0;
    sha_counter = 32'd0;
    checks++;
    if (result_valid !== 1'b1 || result_found !== 1'b1 ||
        result_nonce !== 32'h1234_5678) begin
      errors++;
      $display("FAIL priority got v%b f%b n%h want 1 1 12345678",
               result_valid, result_found, result_nonce);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    start_job(MID_A, HEAD_A);
    flag = 1'b1;
    goldenNonce = 32'hA5A5_5A5A;
    step();
    flag = 1'b0;
    goldenNonce = 32'h0;
    job_midstate = MID_B;
    job_head = HEAD_B;
    job_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid !== 1'b1 || result_found !== 1'b1 ||
          result_nonce !== 32'hA5A5_5A5A || job_ready !== 1'b0 ||
          midState !== MID_A || headData !== HEAD_A || loadState !== 1'b0)
        bad++;
      step();
    end
    job_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL backpressure got %0d bad cycles want 0", bad);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL release got v%b r%b want 0 1", result_valid, job_ready);
    end
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    checks++;
    if (loadState !== 1'b1 || midState !== MID_B) begin
      errors++;
      $display("FAIL turnaround got l%b mid %h want 1 %h",
               loadState, midState[31:0], MID_B[31:0]);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int seen;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({loadState, solveEn, result_valid, job_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_load got %b want 0001",
               {loadState, solveEn, result_valid, job_ready});
    end
    start_job(MID_A, HEAD_A);
    abort = 1'b1;
    flag = 1'b1;
    goldenNonce = 32'h7777_7777;
    step();
    abort = 1'b0;
    flag = 1'b0;
    seen = 0;
    checks++;
    if ({loadState, solveEn, result_valid, job_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_solve got %b want 0001",
               {loadState, solveEn, result_valid, job_ready});
    end
    for (int i = 0; i < 4; i++) begin
      if (result_valid !== 1'b0) seen++;
      step();
    end
    start_job(MID_B, HEAD_B);
    flag = 1'b1;
    step();
    flag = 1'b0;
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort_report got v%b want 1", result_valid);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({loadState, solveEn, result_valid, job_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_report got %b want 0001",
               {loadState, solveEn, result_valid, job_ready});
    end
    for (int i = 0; i < 4; i++) begin
      if (result_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_discard got %0d valid cycles want 0", seen);
    end
    abort = 1'b1;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    abort = 1'b0;
    checks++;
    if (loadState !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle got l%b b%b want 1 1", loadState, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_timeout();
    start_job(MID_A, HEAD_A);
`ifdef JOB_TIMEOUT_EN
    for (int i = 0; i < 49; i++) step();
    checks++;
    if (solveEn !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got s%b v%b want 1 0", solveEn, result_valid);
    end
    step();
    checks++;
    if (result_valid !== 1'b1 || result_timeout !== 1'b1 ||
        result_found !== 1'b0 || result_nonce !== 32'd0) begin
      errors++;
      $display("FAIL timeout got v%b t%b f%b n%h want 1 1 0 0",
               result_valid, result_timeout, result_found, result_nonce);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
`else
    for (int i = 0; i < 60; i++) step();
    checks++;
    if (solveEn !== 1'b1 || result_valid !== 1'b0 ||
        result_timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout got s%b v%b t%b want 1 0 0",
               solveEn, result_valid, result_timeout);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif
  endtask

  task automatic test_async_reset();
    start_job(MID_B, HEAD_B);
    step();
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({job_ready, busy, loadState, solveEn, result_valid} !== 5'b10000 ||
        midState !== '0 || headData !== '0 || result_nonce !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got %b mid %h want 10000 0",
               {job_ready, busy, loadState, solveEn, result_valid},
               midState[31:0]);
    end
    step();
    n_rst = 1'b1;
    step();
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got r%b b%b want 1 0", job_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_found();
    test_exhaust();
    test_backpressure();
    test_abort();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
